// File: rtl/mem_access_ctrl.sv
// Arbiter and wait-state sequencer in front of the unified single-port memory.
// Define MEM_ALIGN_CHECK_EN to fault requests whose address bits below ADDR_SHIFT are non-zero.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_SHIFT  = 0,
  parameter int unsigned MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWriteEnable,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] WORDS     = 32'(MEM_WORDS);
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [31:0] LOW_MASK  = (32'd1 << ADDR_SHIFT) - 32'd1;
`endif

  state_t      state_r;
  logic [3:0]  wait_cnt_r;
  logic        is_data_r;
  logic        we_r;
  logic        fault_r;
  logic        grant_d_s;
  logic        grant_if_s;
  logic [31:0] req_addr_s;
  logic        req_fault_s;

  function automatic logic addr_fault(input logic [31:0] addr);
    logic fault;
    fault = ((addr >> ADDR_SHIFT) >= WORDS);
`ifdef MEM_ALIGN_CHECK_EN
    if ((addr & LOW_MASK) != 32'd0) begin
      fault = 1'b1;
    end else begin
      fault = fault;
    end
`endif
    return fault;
  endfunction

  // Request selection: a pending data request always beats a fetch
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    req_addr_s = if_addr;
    if (d_req) begin
      grant_d_s  = 1'b1;
      req_addr_s = d_addr;
    end else if (if_req) begin
      grant_if_s = 1'b1;
      req_addr_s = if_addr;
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  assign req_fault_s = addr_fault(req_addr_s);

  // Access sequencer: grant, count wait states, commit/capture, then pulse the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      wait_cnt_r     <= 4'd0;
      is_data_r      <= 1'b0;
      we_r           <= 1'b0;
      fault_r        <= 1'b0;
      busy           <= 1'b0;
      if_ack         <= 1'b0;
      if_err         <= 1'b0;
      if_rdata       <= 32'd0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      d_rdata        <= 32'd0;
      memAddress     <= 32'd0;
      memWriteData   <= 32'd0;
      memWriteEnable <= 1'b0;
    end else begin
      if_ack         <= 1'b0;
      if_err         <= 1'b0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      memWriteEnable <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s || grant_if_s) begin
            state_r    <= ACCESS;
            busy       <= 1'b1;
            is_data_r  <= grant_d_s;
            we_r       <= grant_d_s & d_we;
            fault_r    <= req_fault_s;
            wait_cnt_r <= WAIT_INIT;
            memAddress <= req_addr_s >> ADDR_SHIFT;
            if (grant_d_s) begin
              memWriteData <= d_wdata;
            end
            // With no wait states the first ACCESS cycle is also the commit cycle
            memWriteEnable <= grant_d_s & d_we & ~req_fault_s & (WAIT_INIT == 4'd0);
          end
        end
        ACCESS: begin
          if (wait_cnt_r == 4'd0) begin
            state_r <= RESP;
            if (!we_r) begin
              if (is_data_r) begin
                d_rdata <= fault_r ? 32'd0 : memReadData;
              end else begin
                if_rdata <= fault_r ? 32'd0 : memReadData;
              end
            end
            d_ack  <= is_data_r;
            d_err  <= is_data_r & fault_r;
            if_ack <= ~is_data_r;
            if_err <= ~is_data_r & fault_r;
          end else begin
            wait_cnt_r     <= wait_cnt_r - 4'd1;
            memWriteEnable <= we_r & ~fault_r & (wait_cnt_r == 4'd1);
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances (WS0, WS3, WS2 with byte addressing),
// each with its own memory model; responses checked against a scoreboard queue.
module tb_mem_access_ctrl;

  typedef struct {
    int          inst;
    logic        is_d;
    logic        chk;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        mem_init;
  logic        rst_s      [3];
  logic        if_req_s   [3];
  logic [31:0] if_addr_s  [3];
  logic        if_ack_s   [3];
  logic [31:0] if_rdata_s [3];
  logic        if_err_s   [3];
  logic        d_req_s    [3];
  logic        d_we_s     [3];
  logic [31:0] d_addr_s   [3];
  logic [31:0] d_wdata_s  [3];
  logic        d_ack_s    [3];
  logic [31:0] d_rdata_s  [3];
  logic        d_err_s    [3];
  logic        busy_s     [3];
  logic [31:0] maddr_s    [3];
  logic [31:0] mwd_s      [3];
  logic        mwe_s      [3];
  logic [31:0] mrd_s      [3];
  logic [31:0] mem        [3][1024];
  int          we_cnt     [3];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(
      .WAIT_STATES((g == 1) ? 3 : ((g == 2) ? 2 : 0)),
      .ADDR_SHIFT ((g == 2) ? 2 : 0),
      .MEM_WORDS  (1024)
    ) u_dut (
      .clk           (clk),
      .reset         (rst_s[g]),
      .if_req        (if_req_s[g]),
      .if_addr       (if_addr_s[g]),
      .if_ack        (if_ack_s[g]),
      .if_rdata      (if_rdata_s[g]),
      .if_err        (if_err_s[g]),
      .d_req         (d_req_s[g]),
      .d_we          (d_we_s[g]),
      .d_addr        (d_addr_s[g]),
      .d_wdata       (d_wdata_s[g]),
      .d_ack         (d_ack_s[g]),
      .d_rdata       (d_rdata_s[g]),
      .d_err         (d_err_s[g]),
      .busy          (busy_s[g]),
      .memAddress    (maddr_s[g]),
      .memWriteData  (mwd_s[g]),
      .memWriteEnable(mwe_s[g]),
      .memReadData   (mrd_s[g])
    );
    assign mrd_s[g] = (maddr_s[g] < 32'd1024) ? mem[g][maddr_s[g][9:0]] : 32'd0;
  end

  // Memory models: preload during init, write on the edge closing a write-enable cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) begin
          mem[k][i] <= (i == 5) ? 32'd5 : ((i == 128) ? 32'h00221820 : 32'd0);
        end
      end else if (mwe_s[k] && (maddr_s[k] < 32'd1024)) begin
        mem[k][maddr_s[k][9:0]] <= mwd_s[k];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every ack must match the oldest scoreboard entry
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mwe_s[k]) we_cnt[k] <= we_cnt[k] + 1;
      if (d_ack_s[k] || if_ack_s[k]) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("ack_inst", 32'(k), 32'(mon_e.inst));
          check("ack_port", 32'({d_ack_s[k], if_ack_s[k]}), mon_e.is_d ? 32'd2 : 32'd1);
          check("ack_cycle", 32'(cyc), 32'(mon_e.due));
          check("err", 32'(mon_e.is_d ? d_err_s[k] : if_err_s[k]), 32'(mon_e.err));
          if (mon_e.chk) begin
            check("rdata", mon_e.is_d ? d_rdata_s[k] : if_rdata_s[k], mon_e.rdata);
          end
        end
      end
    end
  end

  function automatic int ws_of(input int k);
    return (k == 1) ? 3 : ((k == 2) ? 2 : 0);
  endfunction

  task automatic push(input int k, input logic is_d, input logic chk,
                      input logic [31:0] rdata, input logic err, input int due);
    exp_t e;
    e.inst = k; e.is_d = is_d; e.chk = chk; e.rdata = rdata; e.err = err; e.due = due;
    sb.push_back(e);
  endtask

  task automatic req_d(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    d_we_s[k] = we; d_addr_s[k] = addr; d_wdata_s[k] = wd; d_req_s[k] = 1'b1;
  endtask

  task automatic req_if(input int k, input logic [31:0] addr);
    if_addr_s[k] = addr; if_req_s[k] = 1'b1;
  endtask

  // Requester behaviour: drop each request on its ack; bounded wait
  task automatic wait_done(input int k, output int busy_n);
    logic seen;
    seen   = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 40 && (d_req_s[k] || if_req_s[k]); i++) begin
      @(negedge clk);
      if (d_ack_s[k] || if_ack_s[k]) seen = 1'b1;
      else if (busy_s[k] && !seen) busy_n++;
      if (d_ack_s[k]) d_req_s[k] = 1'b0;
      if (if_ack_s[k]) if_req_s[k] = 1'b0;
    end
    check("req_done", 32'({d_req_s[k], if_req_s[k]}), 32'd0);
    d_req_s[k] = 1'b0; if_req_s[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c, w0, bn;
    mem_init = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; if_req_s[k] = 1'b0; if_addr_s[k] = 32'd0; d_req_s[k] = 1'b0;
      d_we_s[k] = 1'b0; d_addr_s[k] = 32'd0; d_wdata_s[k] = 32'd0; we_cnt[k] = 0;
    end
    @(negedge clk);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_acks", 32'({if_ack_s[0], d_ack_s[0], if_err_s[0], d_err_s[0], mwe_s[0]}), 32'd0);
    check("rst_maddr", maddr_s[0], 32'd0);
    check("rst_mwd", mwd_s[0], 32'd0);
    check("rst_rdata", if_rdata_s[0] | d_rdata_s[0], 32'd0);
    @(negedge clk);
    mem_init = 1'b0;
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    @(negedge clk);

    // Fetch of word 128
    c = cyc; req_if(0, 32'd128); push(0, 1'b0, 1'b1, 32'h00221820, 1'b0, c + 2);
    wait_done(0, bn);
    // Store then load back word 20
    w0 = we_cnt[0]; c = cyc; req_d(0, 1'b1, 32'd20, 32'hDEADBEEF);
    push(0, 1'b1, 1'b0, 32'd0, 1'b0, c + 2);
    wait_done(0, bn);
    check("store_we_pulses", 32'(we_cnt[0] - w0), 32'd1);
    c = cyc; req_d(0, 1'b0, 32'd20, 32'd0); push(0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, c + 2);
    wait_done(0, bn);
    // Simultaneous requests: data first, fetch three cycles later
    c = cyc; req_d(0, 1'b0, 32'd5, 32'd0); req_if(0, 32'd128);
    push(0, 1'b1, 1'b1, 32'd5, 1'b0, c + 2);
    push(0, 1'b0, 1'b1, 32'h00221820, 1'b0, c + 5);
    wait_done(0, bn);
    // Range faults on the first out-of-range word, plus in-range boundary
    w0 = we_cnt[0]; c = cyc; req_d(0, 1'b1, 32'd1024, 32'h12345678);
    push(0, 1'b1, 1'b0, 32'd0, 1'b1, c + 2);
    wait_done(0, bn);
    check("fault_no_we", 32'(we_cnt[0] - w0), 32'd0);
    c = cyc; req_d(0, 1'b0, 32'd0, 32'd0); push(0, 1'b1, 1'b1, 32'd0, 1'b0, c + 2);
    wait_done(0, bn);
    c = cyc; req_if(0, 32'd2000); push(0, 1'b0, 1'b1, 32'd0, 1'b1, c + 2);
    wait_done(0, bn);
    c = cyc; req_d(0, 1'b0, 32'd1023, 32'd0); push(0, 1'b1, 1'b1, 32'd0, 1'b0, c + 2);
    wait_done(0, bn);

    // Three wait states
    c = cyc; req_d(1, 1'b0, 32'd5, 32'd0); push(1, 1'b1, 1'b1, 32'd5, 1'b0, c + 2 + ws_of(1));
    wait_done(1, bn);
    check("ws3_busy_cycles", 32'(bn), 32'd4);

    // Reset in the commit cycle of a store (byte address 40 -> word 10)
    req_d(2, 1'b1, 32'd40, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1 check("rst_mid_we_before", 32'(mwe_s[2]), 32'd1);
    #1 rst_s[2] = 1'b1;
    #1 check("rst_mid_we_after", 32'({mwe_s[2], busy_s[2]}), 32'd0);
    @(negedge clk); d_req_s[2] = 1'b0;
    @(negedge clk); rst_s[2] = 1'b0;
    @(negedge clk);
    c = cyc; req_d(2, 1'b0, 32'd40, 32'd0); push(2, 1'b1, 1'b1, 32'd0, 1'b0, c + 2 + ws_of(2));
    wait_done(2, bn);
    // Byte addressing: aligned load of word 5, then a misaligned one
    c = cyc; req_d(2, 1'b0, 32'd20, 32'd0); push(2, 1'b1, 1'b1, 32'd5, 1'b0, c + 2 + ws_of(2));
    wait_done(2, bn);
    c = cyc; req_d(2, 1'b0, 32'd22, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    push(2, 1'b1, 1'b1, 32'd0, 1'b1, c + 2 + ws_of(2));
`else
    push(2, 1'b1, 1'b1, 32'd5, 1'b0, c + 2 + ws_of(2));
`endif
    wait_done(2, bn);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
